commit_trace: RTL and testbench
===============================

COMMIT_TRACE -- requirements
Module: commit_trace

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entry count (power of two, >=4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rf_we  input  1  register-file write strobe.
REQ-005 SHALL have port rf_waddr  input  5  register-file write index.
REQ-006 SHALL have port rf_wdata  input  32  register-file write data.
REQ-007 SHALL have port hilo_we  input  1  hi/lo write strobe.
REQ-008 SHALL have port hilo_wdata  input  64  new {hi,lo}.
REQ-009 SHALL have port ev_valid  output  1  FIFO head holds an event.
REQ-010 SHALL have port ev_ready  input  1  consumer accepts head.
REQ-011 SHALL have port ev_tag  output  6  event tag: 0-31 = $n, 32 = hi, 33 = lo.
REQ-012 SHALL have port ev_data  output  32  event value.
REQ-013 SHALL have port ev_count  output  $clog2(DEPTH)+1  occupied entries.
REQ-014 SHALL have port overflow  output  1  sticky: events were dropped.

Function
REQ-015 SHALL keep shadow copies of $1-$31, hi and lo, updated on every accepted write regardless of FIFO state.
REQ-016 SHALL generate a register event only when rf_we=1, rf_waddr!=0 and rf_wdata differs from the shadow value.
REQ-017 SHALL generate a hi event when hilo_we=1 and hilo_wdata[63:32] differs from shadow hi, and a lo event when hilo_wdata[31:0] differs from shadow lo.
REQ-018 SHALL enqueue same-cycle events in the fixed order: register, hi, lo (0 to 3 pushes per cycle).
REQ-019 SHALL make an event visible on ev_valid/ev_tag/ev_data exactly one cycle after the write strobe.
REQ-020 SHALL pop the head on a cycle with ev_valid=1 and ev_ready=1; ev_tag/ev_data SHALL remain stable while ev_valid=1 and ev_ready=0.
REQ-021 SHALL evaluate free space as DEPTH - ev_count + (1 if a pop occurs this cycle), so a pop and pushes in the same cycle are legal.
REQ-022 SHALL, when free space is less than the number of events in a cycle, drop all of that cycle's events (no partial push) and set overflow.
REQ-023 SHALL keep overflow set until reset; the shadow update of REQ-015 SHALL still occur on a dropped cycle.
REQ-024 SHALL treat read and write pointers as modulo DEPTH, wrapping without a bubble.
REQ-025 SHALL ignore ev_ready when ev_valid=0.

Reset
REQ-026 SHALL, on rst_n=0, immediately force ev_valid=0, ev_count=0, overflow=0, empty the FIFO and clear all shadow values to 0.
REQ-027 SHALL discard any in-flight or stored events when reset asserts mid-operation; ev_tag/ev_data are don't-care while ev_valid=0.
REQ-028 SHALL sample no inputs while rst_n=0 and SHALL record the first write strobe after deassertion normally.

Structure
REQ-029 SHALL take the tag constants (TAG_HI=32, TAG_LO=33) and the event struct {tag[5:0], data[31:0]} from the shared CPU package.
REQ-030 SHALL implement storage as one sub-module, trace_fifo, with a 3-wide push port and a 1-wide pop port; change detection and ordering SHALL live in commit_trace.

Verification
REQ-031 SHALL cover: after reset, write $3=0x00000005 -> one event (3, 0x00000005) one cycle later; a repeat write of 5 to $3 -> no event.
REQ-032 SHALL cover: write $0=0xFFFFFFFF -> no event, ev_count stays 0.
REQ-033 SHALL cover: in one cycle, $8=0x12 together with hilo=0x00000001_00000002 -> events (8,0x12), (32,0x1), (33,0x2) in that order.
REQ-034 SHALL cover: ev_ready=0, fill DEPTH=16 entries, then a 3-event cycle -> all three dropped, overflow=1, ev_count=16; a later pop and push in the same cycle -> ev_count=16.
REQ-035 SHALL cover: ev_ready toggling randomly over 100 writes -> the output sequence equals the reference change list, with no loss or duplication, across pointer wrap.
REQ-036 SHALL cover: assert rst_n low with 5 queued entries -> ev_valid=0 and ev_count=0 immediately; after release, writing the same $3 value as before reset produces an event (shadow was cleared).

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared CPU-trace definitions: event tags for hi/lo and the event record
// carried through the commit-trace FIFO.
package commit_trace_pkg;

  localparam logic [5:0] TAG_HI = 6'd32;
  localparam logic [5:0] TAG_LO = 6'd33;

  // Maximum events produced by one commit cycle: register, hi, lo.
  localparam int PUSH_W = 3;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] data;
  } trace_ev_t;

endpackage

// File: rtl/commit_trace_fifo.sv
// Event FIFO with a 3-wide all-or-nothing push port and a 1-wide pop port.
// A cycle whose events do not all fit is dropped whole and flagged on drop.
module trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               push_cnt,
  input  trace_ev_t [PUSH_W-1:0]   push_ev,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output trace_ev_t                pop_ev,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_ev_t         mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     free;
  logic              pop;
  logic              accept;

  always_comb begin
    pop      = (count_q != '0) && pop_ready;
    // A same-cycle pop frees a slot for this cycle's pushes.
    free     = CW'(DEPTH) - count_q + CW'(pop);
    accept   = CW'(push_cnt) <= free;
    drop     = !accept;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = accept ? wr_ptr_q + AW'(push_cnt) : wr_ptr_q;
    count_d  = count_q - CW'(pop) + (accept ? CW'(push_cnt) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; an entry is only read once count covers it,
  // so clearing the pointers and count is enough to empty the FIFO.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_W; i++) begin
      if (accept && (2'(i) < push_cnt)) begin
        mem_q[AW'(wr_ptr_q + AW'(i))] <= push_ev[i];
      end
    end
  end

  assign pop_valid = (count_q != '0);
  assign pop_ev    = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/commit_trace.sv
// Commit-trace capture: compares register-file and hi/lo writes against shadow
// copies and queues one event per changed value, in register/hi/lo order.
module commit_trace
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rf_we,
  input  logic [4:0]               rf_waddr,
  input  logic [31:0]              rf_wdata,
  input  logic                     hilo_we,
  input  logic [63:0]              hilo_wdata,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [5:0]               ev_tag,
  output logic [31:0]              ev_data,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow
);

  logic [31:0]             rf_shadow_q [32];
  logic [31:0]             rf_shadow_d [32];
  logic [31:0]             hi_q, hi_d, lo_q, lo_d;
  logic                    overflow_q, overflow_d;
  logic                    rf_chg, hi_chg, lo_chg;
  trace_ev_t               rf_ev, hi_ev, lo_ev, head_ev;
  trace_ev_t [PUSH_W-1:0]  push_ev;
  logic [1:0]              push_cnt;
  logic                    drop;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path through the block can infer a latch.
  always_comb begin
    rf_ev.tag  = {1'b0, rf_waddr};
    rf_ev.data = rf_wdata;
    hi_ev.tag  = TAG_HI;
    hi_ev.data = hilo_wdata[63:32];
    lo_ev.tag  = TAG_LO;
    lo_ev.data = hilo_wdata[31:0];

    rf_chg = rf_we && (rf_waddr != 5'd0) && (rf_wdata != rf_shadow_q[rf_waddr]);
    hi_chg = hilo_we && (hilo_wdata[63:32] != hi_q);
    lo_chg = hilo_we && (hilo_wdata[31:0] != lo_q);

    // Pack the present events into the low push slots, keeping their order.
    push_cnt   = 2'(rf_chg) + 2'(hi_chg) + 2'(lo_chg);
    push_ev[0] = rf_chg ? rf_ev : (hi_chg ? hi_ev : lo_ev);
    push_ev[1] = (rf_chg && hi_chg) ? hi_ev : lo_ev;
    push_ev[2] = lo_ev;

    // Shadows follow every write, whether or not the FIFO takes the events.
    rf_shadow_d = rf_shadow_q;
    if (rf_we && (rf_waddr != 5'd0)) begin
      rf_shadow_d[rf_waddr] = rf_wdata;
    end
    hi_d = hilo_we ? hilo_wdata[63:32] : hi_q;
    lo_d = hilo_we ? hilo_wdata[31:0]  : lo_q;

    overflow_d = overflow_q | drop;
  end

  // NOTE: the shadows are reset (unlike FIFO storage) because change detection
  // reads them immediately after reset and must compare against zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        rf_shadow_q[i] <= '0;
      end
      hi_q       <= '0;
      lo_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      rf_shadow_q <= rf_shadow_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      overflow_q  <= overflow_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_cnt  (push_cnt),
    .push_ev   (push_ev),
    .pop_ready (ev_ready),
    .pop_valid (ev_valid),
    .pop_ev    (head_ev),
    .count     (ev_count),
    .drop      (drop)
  );

  assign ev_tag   = head_ev.tag;
  assign ev_data  = head_ev.data;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_commit_trace.sv
// Self-checking bench for commit_trace: queue-based reference model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_commit_trace;
  import commit_trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic        hilo_we = 1'b0;
  logic [63:0] hilo_wdata = '0;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [5:0]  ev_tag;
  logic [31:0] ev_data;
  logic [4:0]  ev_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  commit_trace #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .hilo_we    (hilo_we),
    .hilo_wdata (hilo_wdata),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_tag     (ev_tag),
    .ev_data    (ev_data),
    .ev_count   (ev_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: queue of pending events, plain shadow arrays.
  trace_ev_t   mq[$];
  trace_ev_t   m_new[$];
  logic [31:0] m_rf [32];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          m_ovf = 1'b0;
  int          m_free;
  int          m_pushes = 0;
  int          dut_pops = 0;

  initial foreach (m_rf[i]) m_rf[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      foreach (m_rf[i]) m_rf[i] = '0;
      m_hi  = '0;
      m_lo  = '0;
      m_ovf = 1'b0;
    end else begin
      m_new.delete();
      if (rf_we && rf_waddr != 0 && rf_wdata != m_rf[rf_waddr])
        m_new.push_back('{tag: {1'b0, rf_waddr}, data: rf_wdata});
      if (hilo_we && hilo_wdata[63:32] != m_hi)
        m_new.push_back('{tag: TAG_HI, data: hilo_wdata[63:32]});
      if (hilo_we && hilo_wdata[31:0] != m_lo)
        m_new.push_back('{tag: TAG_LO, data: hilo_wdata[31:0]});
      m_free = DEPTH - mq.size();
      if (mq.size() > 0 && ev_ready) begin
        void'(mq.pop_front());
      end
      m_free = DEPTH - mq.size();
      if (m_new.size() > m_free) begin
        m_ovf = 1'b1;
      end else begin
        foreach (m_new[i]) mq.push_back(m_new[i]);
        m_pushes += m_new.size();
      end
      if (rf_we && rf_waddr != 0) m_rf[rf_waddr] = rf_wdata;
      if (hilo_we) begin
        m_hi = hilo_wdata[63:32];
        m_lo = hilo_wdata[31:0];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_valid", 64'(ev_valid), 64'(mq.size() != 0));
      check("model_count", 64'(ev_count), 64'(mq.size()));
      check("model_overflow", 64'(overflow), 64'(m_ovf));
      if (mq.size() != 0) begin
        check("model_tag", 64'(ev_tag), 64'(mq[0].tag));
        check("model_data", 64'(ev_data), 64'(mq[0].data));
      end
      if (ev_valid && ev_ready) dut_pops++;
    end
  end

  task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d,
                      input logic hwe, input logic [63:0] hd, input logic rdy);
    rf_we      = we;
    rf_waddr   = a;
    rf_wdata   = d;
    hilo_we    = hwe;
    hilo_wdata = hd;
    ev_ready   = rdy;
    @(posedge clk);
    #1;
    rf_we   = 1'b0;
    hilo_we = 1'b0;
  endtask

  int p0, m0;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(ev_valid), 64'd0);
    check("reset_count", 64'(ev_count), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First change produces one event one cycle later; a repeat does not.
    step(1, 5'd3, 32'h5, 0, '0, 0);
    check("w3_valid", 64'(ev_valid), 64'd1);
    check("w3_tag", 64'(ev_tag), 64'd3);
    check("w3_data", 64'(ev_data), 64'h5);
    step(1, 5'd3, 32'h5, 0, '0, 0);
    check("w3_repeat_count", 64'(ev_count), 64'd1);
    step(0, 5'd0, 32'h0, 0, '0, 1);
    check("w3_popped_count", 64'(ev_count), 64'd0);

    // Writes to $0 never generate events.
    step(1, 5'd0, 32'hFFFF_FFFF, 0, '0, 0);
    check("w0_count", 64'(ev_count), 64'd0);

    // Register, hi and lo changes in one cycle, enqueued in that order.
    step(1, 5'd8, 32'h12, 1, {32'h1, 32'h2}, 0);
    check("tri_count", 64'(ev_count), 64'd3);
    check("tri_tag0", 64'(ev_tag), 64'd8);
    check("tri_data0", 64'(ev_data), 64'h12);
    step(0, 5'd0, 32'h0, 0, '0, 1);
    check("tri_tag1", 64'(ev_tag), 64'd32);
    check("tri_data1", 64'(ev_data), 64'h1);
    step(0, 5'd0, 32'h0, 0, '0, 1);
    check("tri_tag2", 64'(ev_tag), 64'd33);
    check("tri_data2", 64'(ev_data), 64'h2);
    step(0, 5'd0, 32'h0, 0, '0, 1);
    check("tri_drained", 64'(ev_count), 64'd0);

    // Fill, overflow a 3-event cycle, then pop and push together when full.
    for (int i = 0; i < DEPTH; i++) step(1, 5'(10 + i), 32'(100 + i), 0, '0, 0);
    check("full_count", 64'(ev_count), 64'd16);
    check("full_no_ovf", 64'(overflow), 64'd0);
    step(1, 5'd9, 32'h77, 1, {32'hAA, 32'hBB}, 0);
    check("drop_count", 64'(ev_count), 64'd16);
    check("drop_overflow", 64'(overflow), 64'd1);
    step(1, 5'd26, 32'h55, 0, '0, 1);
    check("poppush_count", 64'(ev_count), 64'd16);
    check("poppush_tag", 64'(ev_tag), 64'd11);
    check("poppush_data", 64'(ev_data), 64'd101);
    repeat (DEPTH) step(0, 5'd0, 32'h0, 0, '0, 1);
    check("full_drained", 64'(ev_count), 64'd0);
    // Shadows were updated on the dropped cycle, so these are not changes.
    step(1, 5'd9, 32'h77, 0, '0, 0);
    step(0, 5'd0, 32'h0, 1, {32'hAA, 32'hBB}, 0);
    check("dropped_shadow_count", 64'(ev_count), 64'd0);
    check("overflow_sticky", 64'(overflow), 64'd1);

    // Random writes with random back-pressure across pointer wrap.
    p0 = dut_pops;
    m0 = m_pushes;
    for (int i = 0; i < 100; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 32'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0,
           {32'($urandom_range(0, 1)), 32'($urandom_range(0, 1))},
           1'($urandom_range(0, 1)));
    end
    repeat (40) step(0, 5'd0, 32'h0, 0, '0, 1);
    check("rand_drained", 64'(ev_count), 64'd0);
    check("rand_pops_eq_pushes", 64'(dut_pops - p0), 64'(m_pushes - m0));

    // Reset with five queued entries clears everything, shadows included.
    step(1, 5'd3, 32'hA5A5, 0, '0, 0);
    for (int i = 4; i < 8; i++) step(1, 5'(i), 32'(32'hA000 + i), 0, '0, 0);
    check("prereset_count", 64'(ev_count), 64'd5);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", 64'(ev_valid), 64'd0);
    check("midreset_count", 64'(ev_count), 64'd0);
    check("midreset_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 5'd3, 32'hA5A5, 0, '0, 0);
    check("postreset_count", 64'(ev_count), 64'd1);
    check("postreset_tag", 64'(ev_tag), 64'd3);
    check("postreset_data", 64'(ev_data), 64'hA5A5);
    step(0, 5'd0, 32'h0, 0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
